// File: rtl/run_ctrl_pkg.sv
// Shared types, default constants and helpers for the run controller.
package run_ctrl_pkg;

   localparam int unsigned RC_PC_W       = 12;
   localparam int unsigned RC_CNT_W      = 16;
   localparam int unsigned RC_MEM_LAT    = 2;
   localparam int unsigned RC_MAX_CYCLES = 4096;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_DONE   = 3'd6
   } run_state_t;

   // Increment v, holding at the all-ones value of a w-bit counter.
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
      logic [31:0] max_v;
      if (w >= 32) max_v = '1;
      else         max_v = (32'd1 << w) - 32'd1;
      return (v >= max_v) ? max_v : v + 32'd1;
   endfunction

endpackage

// File: rtl/run_ctrl_lat_timer.sv
// Loadable down-counter timing the data-memory access latency.
// first: high during the cycle right after load; expire: count is zero.
module lat_timer #(
   parameter int unsigned LAT = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   output logic first,
   output logic expire
);

   logic [3:0] cnt;
   logic       first_q;

   // Load with LAT-1 so the counter reads zero in the final access cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt     <= '0;
         first_q <= 1'b0;
      end else if (load) begin
         cnt     <= 4'(LAT - 1);
         first_q <= 1'b1;
      end else begin
         first_q <= 1'b0;
         if (cnt != '0) cnt <= cnt - 4'd1;
      end
   end

   // Expose status directly from the registers.
   always_comb begin
      first  = first_q;
      expire = (cnt == '0);
   end

endmodule

// File: rtl/run_ctrl.sv
// Multi-cycle run controller: FETCH/DECODE/EXEC/MEM/WB sequencing, PC
// ownership, write-strobe gating, req/done handshake, watchdog and counters.
// Optional macro RUN_CTRL_SINGLE_STEP_EN adds step_mode/step ports that
// stall FETCH until a rising edge on step.
module run_ctrl
   import run_ctrl_pkg::*;
#(
   parameter int unsigned PC_W       = RC_PC_W,
   parameter int unsigned CNT_W      = RC_CNT_W,
   parameter int unsigned MEM_LAT    = RC_MEM_LAT,
   parameter int unsigned START_PC   = 0,
   parameter int unsigned MAX_CYCLES = RC_MAX_CYCLES
) (
   input  logic             clk,
   input  logic             reset,
`ifdef RUN_CTRL_SINGLE_STEP_EN
   input  logic             step_mode,
   input  logic             step,
`endif
   input  logic             req,
   input  logic             halt_instr,
   input  logic             is_mem,
   input  logic             is_store,
   input  logic             reg_write,
   input  logic             branch_taken,
   input  logic [PC_W-1:0]  branch_target,
   output logic [PC_W-1:0]  pc,
   output logic             ir_load,
   output logic             rf_we,
   output logic             dm_we,
   output logic             busy,
   output logic             done,
   output logic             timeout,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instr_cnt
);

   localparam logic [PC_W-1:0] START = PC_W'(START_PC);

   run_state_t      state, state_nxt;
   logic            stall, wd_hit, start, mem_load, mem_first, mem_expire;
   logic            br_taken_q;
   logic [PC_W-1:0] br_target_q;

`ifdef RUN_CTRL_SINGLE_STEP_EN
   logic step_q;

   // Remember the previous step level for rising-edge detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) step_q <= 1'b0;
      else        step_q <= step;
   end

   // Hold in FETCH under step mode until step rises.
   always_comb stall = (state == ST_FETCH) && step_mode && !(step && !step_q);
`else
   // No single-step support: FETCH always proceeds.
   always_comb stall = 1'b0;
`endif

   // Status decode and watchdog condition.
   always_comb begin
      busy     = (state != ST_IDLE) && (state != ST_DONE);
      done     = (state == ST_DONE);
      start    = !busy && req;
      wd_hit   = busy && !stall && (32'(cycle_cnt) == MAX_CYCLES - 1);
      mem_load = (state == ST_EXEC) && is_mem && !wd_hit;
   end

   lat_timer #(.LAT(MEM_LAT)) u_lat (
      .clk    (clk),
      .reset  (reset),
      .load   (mem_load),
      .first  (mem_first),
      .expire (mem_expire)
   );

   // Next-state selection; the watchdog overrides every other transition.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (req) state_nxt = ST_FETCH;
         ST_FETCH:  if (!stall) state_nxt = ST_DECODE;
         ST_DECODE: state_nxt = halt_instr ? ST_DONE : ST_EXEC;
         ST_EXEC:   state_nxt = is_mem ? ST_MEM : ST_WB;
         ST_MEM:    if (mem_expire) state_nxt = ST_WB;
         ST_WB:     state_nxt = ST_FETCH;
         ST_DONE:   if (req) state_nxt = ST_FETCH;
         default:   state_nxt = ST_IDLE;
      endcase
      if (wd_hit) state_nxt = ST_DONE;
   end

   // Strobes are suppressed in the watchdog's final cycle.
   always_comb begin
      ir_load = (state == ST_FETCH) && !stall && !wd_hit;
      rf_we   = (state == ST_WB) && reg_write && !wd_hit;
      dm_we   = (state == ST_MEM) && mem_first && is_store && !wd_hit;
   end

   // State, PC, counters, timeout flag and branch latch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         pc          <= START;
         cycle_cnt   <= '0;
         instr_cnt   <= '0;
         timeout     <= 1'b0;
         br_taken_q  <= 1'b0;
         br_target_q <= '0;
      end else begin
         state <= state_nxt;
         if (start) begin
            pc        <= START;
            cycle_cnt <= '0;
            instr_cnt <= '0;
            timeout   <= 1'b0;
         end else begin
            if (busy && !stall)
               cycle_cnt <= CNT_W'(sat_inc(32'(cycle_cnt), CNT_W));
            if (wd_hit)
               timeout <= 1'b1;
            if (state == ST_EXEC) begin
               br_taken_q  <= branch_taken;
               br_target_q <= branch_target;
            end
            if ((state == ST_WB) && !wd_hit) begin
               pc        <= br_taken_q ? br_target_q : pc + 1'b1;
               instr_cnt <= CNT_W'(sat_inc(32'(instr_cnt), CNT_W));
            end
         end
      end
   end

endmodule

// File: tb/tb_run_ctrl.sv
// Directed, table-driven bench for run_ctrl (default build, no single-step).
module tb_run_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_a = 1'b0, req_b = 1'b0;
   logic        halt_instr = 1'b0, is_mem = 1'b0, is_store = 1'b0, reg_write = 1'b0;
   logic        branch_taken = 1'b0;
   logic [11:0] branch_target = '0;

   logic [11:0] a_pc;
   logic        a_ir_load, a_rf_we, a_dm_we, a_busy, a_done, a_timeout;
   logic [15:0] a_cc, a_ic;
   logic [3:0]  b_pc;
   logic        b_ir_load, b_rf_we, b_dm_we, b_busy, b_done, b_timeout;
   logic [15:0] b_cc, b_ic;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   run_ctrl #(.PC_W(12), .CNT_W(16), .MEM_LAT(2), .START_PC(16), .MAX_CYCLES(4096)) dut_a (
      .clk(clk), .reset(reset), .req(req_a), .halt_instr(halt_instr), .is_mem(is_mem),
      .is_store(is_store), .reg_write(reg_write), .branch_taken(branch_taken),
      .branch_target(branch_target), .pc(a_pc), .ir_load(a_ir_load), .rf_we(a_rf_we),
      .dm_we(a_dm_we), .busy(a_busy), .done(a_done), .timeout(a_timeout),
      .cycle_cnt(a_cc), .instr_cnt(a_ic));

   run_ctrl #(.PC_W(4), .CNT_W(16), .MEM_LAT(2), .START_PC(15), .MAX_CYCLES(20)) dut_b (
      .clk(clk), .reset(reset), .req(req_b), .halt_instr(halt_instr), .is_mem(is_mem),
      .is_store(is_store), .reg_write(reg_write), .branch_taken(branch_taken),
      .branch_target(branch_target[3:0]), .pc(b_pc), .ir_load(b_ir_load), .rf_we(b_rf_we),
      .dm_we(b_dm_we), .busy(b_busy), .done(b_done), .timeout(b_timeout),
      .cycle_cnt(b_cc), .instr_cnt(b_ic));

   typedef struct {
      bit          start;
      bit          halt;
      bit          mem;
      bit          store;
      bit          rw;
      bit          tk;
      logic [11:0] tgt;
      int          cyc;
      int          rf;
      int          dm;
      logic [11:0] pc;
      int          icnt;
      int          cc;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Pulse req for one cycle from a negedge; the DUT is in FETCH afterwards.
   task automatic start_run(input bit b);
      if (b) req_b = 1'b1; else req_a = 1'b1;
      @(negedge clk);
      req_a = 1'b0;
      req_b = 1'b0;
      chk("start_ir_load", b ? b_ir_load : a_ir_load, 1);
   endtask

   // From a FETCH negedge, run until the next FETCH or DONE, counting strobes.
   task automatic step_instr(input bit b, output int cyc, output int rf, output int dm);
      bit fin;
      cyc = 0; rf = 0; dm = 0; fin = 1'b0;
      while (!fin) begin
         rf += int'(b ? b_rf_we : a_rf_we);
         dm += int'(b ? b_dm_we : a_dm_we);
         cyc++;
         @(posedge clk);
         @(negedge clk);
         if (b ? (b_ir_load || b_done) : (a_ir_load || a_done)) fin = 1'b1;
         else if (cyc >= 64) begin
            chk("instr_bound", cyc, 0);
            fin = 1'b1;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got stuck expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      int cyc, rf, dm, tot, rft;

      //               start halt mem st rw tk tgt      cyc rf dm pc       icnt cc
      vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h0A5, 4, 1, 0, 12'h011, 1, 0};
      vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 4, 1, 0, 12'h012, 2, 0};
      vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 4, 0, 0, 12'h013, 3, 0};
      vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 2, 0, 0, 12'h013, 3, 14};
      vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h0A5, 4, 0, 0, 12'h0A5, 1, 0};
      vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 6, 0, 1, 12'h0A6, 2, 0};
      vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 6, 1, 0, 12'h0A7, 3, 0};
      vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h123, 4, 1, 0, 12'h0A8, 4, 0};
      vecs[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 2, 0, 0, 12'h0A8, 4, 22};

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_pc", a_pc, 12'h010);
      chk("rst_busy", a_busy, 0);
      chk("rst_done", a_done, 0);
      chk("rst_timeout", a_timeout, 0);
      chk("rst_cc", a_cc, 0);
      chk("rst_ic", a_ic, 0);
      chk("rst_strobes", {a_ir_load, a_rf_we, a_dm_we}, 0);
      chk("rst_pc_b", b_pc, 15);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         if (vecs[i].start) start_run(1'b0);
         halt_instr    = vecs[i].halt;
         is_mem        = vecs[i].mem;
         is_store      = vecs[i].store;
         reg_write     = vecs[i].rw;
         branch_taken  = vecs[i].tk;
         branch_target = vecs[i].tgt;
         step_instr(1'b0, cyc, rf, dm);
         chk($sformatf("v%0d_cycles", i), cyc, vecs[i].cyc);
         chk($sformatf("v%0d_rf_we", i), rf, vecs[i].rf);
         chk($sformatf("v%0d_dm_we", i), dm, vecs[i].dm);
         chk($sformatf("v%0d_pc", i), a_pc, vecs[i].pc);
         chk($sformatf("v%0d_instr_cnt", i), a_ic, vecs[i].icnt);
         if (vecs[i].halt) begin
            chk($sformatf("v%0d_done", i), a_done, 1);
            chk($sformatf("v%0d_timeout", i), a_timeout, 0);
            chk($sformatf("v%0d_cycle_cnt", i), a_cc, vecs[i].cc);
         end
      end

      // req held high while busy must not restart the run
      halt_instr = 1'b0; is_mem = 1'b0; is_store = 1'b0; reg_write = 1'b0; branch_taken = 1'b0;
      start_run(1'b0);
      req_a = 1'b1;
      step_instr(1'b0, cyc, rf, dm);
      chk("busyreq_cycles", cyc, 4);
      chk("busyreq_pc", a_pc, 12'h011);
      chk("busyreq_ic", a_ic, 1);
      chk("busyreq_cc", a_cc, 4);
      req_a = 1'b0;

      // Reset asserted in the first MEM cycle of a store
      is_mem = 1'b1; is_store = 1'b1;
      repeat (3) @(negedge clk);
      chk("mem_dm_we", a_dm_we, 1);
      reset = 1'b0;
      #1;
      chk("rstmem_busy_async", a_busy, 0);
      @(posedge clk);
      #1;
      chk("rstmem_pc", a_pc, 12'h010);
      chk("rstmem_busy", a_busy, 0);
      chk("rstmem_cc", a_cc, 0);
      chk("rstmem_ic", a_ic, 0);
      chk("rstmem_done", a_done, 0);
      @(negedge clk);
      reset = 1'b1;
      is_mem = 1'b0; is_store = 1'b0;
      @(negedge clk);
      chk("idle_after_rst", a_busy, 0);

      // PC wrap and watchdog on the narrow instance
      reg_write = 1'b1;
      start_run(1'b1);
      chk("wrap_start_pc", b_pc, 15);
      step_instr(1'b1, cyc, rf, dm);
      chk("wrap_pc", b_pc, 0);
      tot = cyc; rft = rf;
      for (int k = 0; k < 10; k++) begin
         if (!b_done) begin
            step_instr(1'b1, cyc, rf, dm);
            tot += cyc; rft += rf;
         end
      end
      chk("wd_busy_cycles", tot, 20);
      chk("wd_rf_we", rft, 4);
      chk("wd_done", b_done, 1);
      chk("wd_timeout", b_timeout, 1);
      chk("wd_cc", b_cc, 20);
      chk("wd_ic", b_ic, 4);
      chk("wd_pc", b_pc, 3);

      start_run(1'b1);
      chk("rerun_timeout", b_timeout, 0);
      chk("rerun_cc", b_cc, 0);
      chk("rerun_ic", b_ic, 0);
      chk("rerun_pc", b_pc, 15);
      chk("rerun_done", b_done, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
